// File: rtl/event_collector.sv
// Collects per-unit spikes into pending registers, arbitrates them round-robin
// into a show-ahead FIFO and presents that FIFO as a valid/ready event stream.
module event_collector #(
   parameter  int NUM_UNITS       = 4,
   parameter  int TS_WIDTH        = 8,
   parameter  int FIFO_ADDR_WIDTH = 3,
   localparam int UID_W           = $clog2(NUM_UNITS),
   localparam int WORD_W          = UID_W + 2 + TS_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_UNITS-1:0]       spike_detection_array,
   input  logic [2*NUM_UNITS-1:0]     event_out_array,
   output logic [WORD_W-1:0]          event_word,
   output logic                       event_valid,
   input  logic                       event_ready,
   output logic [FIFO_ADDR_WIDTH:0]   fifo_level,
   output logic [7:0]                 overflow_count
);

   localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;

   logic [TS_WIDTH-1:0]        r_ts;
   logic [UID_W-1:0]           r_ptr;
   logic [NUM_UNITS-1:0]       r_pend_valid;
   logic [1:0]                 r_pend_class [NUM_UNITS];
   logic [TS_WIDTH-1:0]        r_pend_ts    [NUM_UNITS];
   logic [WORD_W-1:0]          r_mem        [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
   logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
   logic [FIFO_ADDR_WIDTH:0]   r_level;
   logic [7:0]                 r_ovf;

   logic                       w_pop;
   logic                       w_can_push;
   logic                       w_grant_valid;
   logic [UID_W-1:0]           w_grant_idx;
   logic [WORD_W-1:0]          w_grant_word;
   logic [NUM_UNITS-1:0]       w_granted;
   logic [NUM_UNITS-1:0]       w_drop;
   logic [15:0]                w_drop_cnt;
   logic [15:0]                w_ovf_sum;

   assign w_pop      = (r_level != '0) && event_ready;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign w_can_push = (r_level < (FIFO_ADDR_WIDTH+1)'(DEPTH)) || w_pop;

   always_comb begin
      logic [UID_W-1:0] v_idx;
      w_grant_valid = 1'b0;
      w_grant_idx   = '0;
      v_idx         = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         v_idx = r_ptr + UID_W'(i);
         if (!w_grant_valid && w_can_push && r_pend_valid[v_idx]) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = v_idx;
         end
      end
   end

   assign w_grant_word = {w_grant_idx, r_pend_class[w_grant_idx], r_pend_ts[w_grant_idx]};

   generate
      for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
         assign w_granted[gi] = w_grant_valid && (w_grant_idx == UID_W'(gi));
         assign w_drop[gi]    = spike_detection_array[gi] && r_pend_valid[gi] && !w_granted[gi];
      end
   endgenerate

   always_comb begin
      w_drop_cnt = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         w_drop_cnt = w_drop_cnt + 16'(w_drop[i]);
      end
   end

   assign w_ovf_sum = {8'd0, r_ovf} + w_drop_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ts  <= '0;
         r_ptr <= '0;
         r_ovf <= '0;
      end else begin
         r_ts  <= r_ts + 1'b1;
         r_ovf <= (w_ovf_sum > 16'd255) ? 8'd255 : w_ovf_sum[7:0];
         if (w_grant_valid) begin
            r_ptr <= w_grant_idx + 1'b1;
         end
      end
   end

   // A granted unit frees its slot this edge, so a coincident spike refills it.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_UNITS; k++) begin
         if (rst) begin
            r_pend_valid[k] <= 1'b0;
            r_pend_class[k] <= '0;
            r_pend_ts[k]    <= '0;
         end else if (spike_detection_array[k] && (!r_pend_valid[k] || w_granted[k])) begin
            r_pend_valid[k] <= 1'b1;
            r_pend_class[k] <= event_out_array[2*k +: 2];
            r_pend_ts[k]    <= r_ts;
         end else if (w_granted[k]) begin
            r_pend_valid[k] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_grant_valid && !rst) begin
         r_mem[r_wr_ptr] <= w_grant_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_grant_valid) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_grant_valid, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign event_valid    = (r_level != '0);
   assign event_word     = event_valid ? r_mem[r_rd_ptr] : '0;
   assign fifo_level     = r_level;
   assign overflow_count = r_ovf;

endmodule

// File: tb/tb_event_collector.sv
// Randomized scoreboard bench for event_collector against a queue-based
// per-cycle reference model of the collector's behaviour.
module tb_event_collector;

   localparam int N     = 4;
   localparam int DEPTH = 8;

   logic        clk;
   logic        rst;
   logic [3:0]  spike;
   logic [7:0]  evout;
   logic [11:0] event_word;
   logic        event_valid;
   logic        event_ready;
   logic [3:0]  fifo_level;
   logic [7:0]  overflow_count;

   event_collector #(.NUM_UNITS(4), .TS_WIDTH(8), .FIFO_ADDR_WIDTH(3)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .spike_detection_array (spike),
      .event_out_array       (evout),
      .event_word            (event_word),
      .event_valid           (event_valid),
      .event_ready           (event_ready),
      .fifo_level            (fifo_level),
      .overflow_count        (overflow_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit        v;
      bit [11:0] w;
      int        lvl;
      int        ovf;
   } stat_t;

   stat_t     stat_q[$];
   int        errors = 0;
   int        checks = 0;

   // reference model state
   int        m_ts;
   int        m_ptr;
   int        m_ovf;
   bit        m_pv [N];
   int        m_pc [N];
   int        m_pt [N];
   bit [11:0] m_fifo[$];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ts  = 0;
      m_ptr = 0;
      m_ovf = 0;
      m_fifo.delete();
      for (int k = 0; k < N; k++) begin
         m_pv[k] = 0;
         m_pc[k] = 0;
         m_pt[k] = 0;
      end
   endtask

   // Drive one cycle of inputs and advance the model across the coming edge.
   task automatic step(input bit r, input bit [3:0] sp, input bit [7:0] cl, input bit rdy);
      stat_t     s;
      int        g;
      bit        pop;
      bit [11:0] w;
      bit [1:0]  gu;
      @(negedge clk);
      rst         = r;
      spike       = sp;
      evout       = cl;
      event_ready = rdy;
      if (r) begin
         model_reset();
      end else begin
         pop = (m_fifo.size() > 0) && rdy;
         g   = -1;
         if (m_fifo.size() < DEPTH || pop) begin
            for (int i = 0; i < N; i++) begin
               if (g < 0 && m_pv[(m_ptr + i) % N]) g = (m_ptr + i) % N;
            end
         end
         if (pop) begin
            w = m_fifo.pop_front();
            $display("event pop: unit=%0d class=%0d ts=%0d", w[11:10], w[9:8], w[7:0]);
         end
         if (g >= 0) begin
            gu = g[1:0];
            w  = {gu, m_pc[g][1:0], m_pt[g][7:0]};
            m_fifo.push_back(w);
            m_ptr = (g + 1) % N;
         end
         for (int k = 0; k < N; k++) begin
            if (sp[k]) begin
               if (m_pv[k] && k != g) begin
                  if (m_ovf < 255) m_ovf++;
               end else begin
                  m_pv[k] = 1;
                  m_pc[k] = (cl >> (2 * k)) & 3;
                  m_pt[k] = m_ts;
               end
            end else if (k == g) begin
               m_pv[k] = 0;
            end
         end
         m_ts = (m_ts + 1) % 256;
      end
      s.v   = (m_fifo.size() > 0);
      s.w   = s.v ? m_fifo[0] : 12'd0;
      s.lvl = m_fifo.size();
      s.ovf = m_ovf;
      stat_q.push_back(s);
   endtask

   // Monitor: one expected snapshot per edge, compared just after the edge.
   initial begin
      stat_t s;
      forever begin
         @(posedge clk);
         #1;
         if (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            chk("event_valid", event_valid, s.v);
            chk("event_word", event_word, s.w);
            chk("fifo_level", fifo_level, s.lvl);
            chk("overflow_count", overflow_count, s.ovf);
         end
      end
   end

   initial begin
      rst         = 1'b1;
      spike       = '0;
      evout       = '0;
      event_ready = 1'b0;
      model_reset();

      // reset, then a single unit 2 class 1 spike at ts=5
      step(1, 4'h0, 8'h00, 1);
      step(1, 4'h0, 8'h00, 1);
      while (m_ts != 5) step(0, 4'h0, 8'h00, 1);
      step(0, 4'b0100, 8'b00_01_00_00, 1);
      repeat (4) step(0, 4'h0, 8'h00, 1);

      // all four units at once, classes 0..3
      while (m_ts != 10) step(0, 4'h0, 8'h00, 1);
      step(0, 4'hF, 8'b11_10_01_00, 1);
      repeat (6) step(0, 4'h0, 8'h00, 1);

      // backpressure: fill FIFO, hold pending, drop the rest, then drain
      for (int i = 0; i < 12; i++) begin
         step(0, 4'b0010, 8'($urandom_range(0, 255)), 0);
         step(0, 4'h0, 8'h00, 0);
      end
      repeat (12) step(0, 4'h0, 8'h00, 1);

      // timestamp wrap
      while (m_ts != 255) step(0, 4'h0, 8'h00, 1);
      step(0, 4'b0001, 8'h02, 1);
      step(0, 4'h0, 8'h00, 1);
      step(0, 4'b0001, 8'h03, 1);
      repeat (4) step(0, 4'h0, 8'h00, 1);

      // unit 3 re-spikes in the cycle it is granted
      step(0, 4'b1000, 8'b01_00_00_00, 1);
      step(0, 4'b1000, 8'b10_00_00_00, 1);
      repeat (4) step(0, 4'h0, 8'h00, 1);

      // five queued entries, then a one-cycle reset mid-stream
      step(0, 4'hF, 8'hE4, 0);
      repeat (6) step(0, 4'h0, 8'h00, 0);
      step(0, 4'b0100, 8'h30, 0);
      repeat (3) step(0, 4'h0, 8'h00, 0);
      step(1, 4'hF, 8'hFF, 0);
      repeat (3) step(0, 4'h0, 8'h00, 1);

      // randomized traffic with stretches of backpressure and rare resets
      for (int i = 0; i < 3000; i++) begin
         bit [3:0] sp;
         bit       rdy;
         for (int k = 0; k < N; k++) sp[k] = ($urandom_range(0, 9) < 3);
         rdy = ((i / 64) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         step(($urandom_range(0, 499) == 0), sp, 8'($urandom), rdy);
      end
      repeat (10) step(0, 4'h0, 8'h00, 1);

      @(posedge clk);
      #3;
      chk("scoreboard_drained", stat_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
